pipelined_ripple_adder: RTL and testbench

PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

---
 rtl/pipelined_ripple_adder.sv | 88 ++++++++
 tb/tb_pipelined_ripple_adder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: segmented ripple-carry adder, one SEG_WIDTH slice per stage, valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);
  localparam int STAGES = WIDTH / SEG_WIDTH;
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  // Stage k carries the finished low sum bits forward and only the operand bits not yet added.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG_WIDTH;
    logic [WIDTH-LO-1:0]     a_in, b_in;
    logic                    c_i, v_i;
    logic [SEG_WIDTH:0]      seg;
    logic [LO+SEG_WIDTH-1:0] s_d, s_q;
    logic                    c_q, v_q;
    if (k == 0) begin : g_head
      assign a_in = add_1;
      assign b_in = add_2;
      assign c_i  = c_in;
      assign v_i  = in_valid;
      assign s_d  = seg[SEG_WIDTH-1:0];
    end else begin : g_tail
      assign a_in = g_st[k-1].g_op.a_q;
      assign b_in = g_st[k-1].g_op.b_q;
      assign c_i  = g_st[k-1].c_q;
      assign v_i  = g_st[k-1].v_q;
      assign s_d  = {seg[SEG_WIDTH-1:0], g_st[k-1].s_q};
    end
    assign seg = {1'b0, a_in[SEG_WIDTH-1:0]} + {1'b0, b_in[SEG_WIDTH-1:0]} + {{SEG_WIDTH{1'b0}}, c_i};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        s_q <= s_d;
        c_q <= seg[SEG_WIDTH];
        v_q <= v_i;
      end
    end
    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-LO-SEG_WIDTH-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[WIDTH-LO-1:SEG_WIDTH];
          b_q <= b_in[WIDTH-LO-1:SEG_WIDTH];
        end
      end
    end
  end
  assign sum       = g_st[STAGES-1].s_q;
  assign c_out     = g_st[STAGES-1].c_q;
  assign out_valid = g_st[STAGES-1].v_q;
`ifdef PIPE_ADDER_OVF_EN
  // Carry into the MSB is recovered as a^b^s at that bit; overflow when it differs from carry out.
  logic ovf_q, ovf_d;
  assign ovf_d = g_st[STAGES-1].seg[SEG_WIDTH] ^ g_st[STAGES-1].seg[SEG_WIDTH-1]
               ^ g_st[STAGES-1].a_in[SEG_WIDTH-1] ^ g_st[STAGES-1].b_in[SEG_WIDTH-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (advance) ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: transaction-level scoreboard for the pipelined adder, directed and random stimulus.
module tb_pipelined_ripple_adder;
  localparam int W   = 16;
  localparam int LAT = 4;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, c_in = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, c_out;
  logic [W-1:0] add_1 = '0, add_2 = '0, sum;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;
`endif
  int checks = 0, errors = 0, cyc = 0, stalls = 0;
  logic         held = 1'b0;
  logic [W:0]   held_v = '0;
  typedef struct {logic [W:0] val; logic ov; int t; int st;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(W), .SEG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .add_1(add_1), .add_2(add_2), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef PIPE_ADDER_OVF_EN
    .c_out(c_out), .ovf(ovf)
`else
    .c_out(c_out)
`endif
  );

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic ordy);
    exp_t e;
    int   sa;
    logic [W:0] v;
    in_valid = iv; add_1 = a; add_2 = b; c_in = ci; out_ready = ordy;
    #1;
    check("in_ready", {16'b0, in_ready}, {16'b0, !out_valid || ordy});
    if (held) begin
      check("hold_valid", {16'b0, out_valid}, 17'd1);
      check("hold_sum", {c_out, sum}, held_v);
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) check("unexpected_out", {16'b0, out_valid}, 17'd0);
      else begin
        e = q.pop_front();
        check("result", {c_out, sum}, e.val);
`ifdef PIPE_ADDER_OVF_EN
        check("ovf", {16'b0, ovf}, {16'b0, e.ov});
`endif
        if (e.st == stalls) check("latency", 17'(cyc - e.t), 17'(LAT));
      end
    end
    held   = out_valid && !ordy;
    held_v = {c_out, sum};
    if (held) stalls++;
    if (iv && in_ready) begin
      v  = {1'b0, a};
      v  = v + {1'b0, b} + {16'b0, ci};
      sa = int'($signed(a)) + int'($signed(b)) + int'(ci);
      e.val = v;
      e.ov  = (sa > 32767) || (sa < -32768);
      e.t   = cyc;
      e.st  = stalls;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    check("drain_empty", 17'(q.size()), 17'd0);
  endtask

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 16'hFFFF : r == 1 ? 16'h0000 : r == 2 ? 16'h7FFF : r == 3 ? 16'h8000 : W'($urandom);
  endfunction

  initial begin
    #1;
    check("rst_valid", {16'b0, out_valid}, 17'd0);
    check("rst_sum", {c_out, sum}, 17'd0);
    check("rst_in_ready", {16'b0, in_ready}, 17'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    repeat (LAT) step(1'b0, '0, '0, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 8; i++) step(1'b1, W'(i), W'(16'h1111 * i), i[0], 1'b1);
    drain();
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    drain();
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
    step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {16'b0, out_valid}, 17'd0);
    check("mid_rst_sum", {c_out, sum}, 17'd0);
    check("mid_rst_in_ready", {16'b0, in_ready}, 17'd1);
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom), ($urandom_range(0, 3) != 0));
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
